// File: rtl/mem_burst_arbiter.sv
// rtl/mem_burst_arbiter.sv - icache/dcache arbiter onto one 4-beat burst memory port
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: alternate grants when both caches request.
module mem_burst_arbiter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_W-1:0]       i_addr,
    input  logic                    i_read,
    output logic [BEAT_W*BEATS-1:0] i_rdata,
    output logic                    i_resp,
    input  logic [ADDR_W-1:0]       d_addr,
    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [BEAT_W*BEATS-1:0] d_wdata,
    output logic [BEAT_W*BEATS-1:0] d_rdata,
    output logic                    d_resp,
    output logic [ADDR_W-1:0]       bmem_addr,
    output logic                    bmem_read,
    output logic                    bmem_write,
    output logic [BEAT_W-1:0]       bmem_wdata,
    input  logic                    bmem_ready,
    input  logic [ADDR_W-1:0]       bmem_raddr,
    input  logic [BEAT_W-1:0]       bmem_rdata,
    input  logic                    bmem_rvalid
);

    localparam int LINE_W = BEAT_W * BEATS;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_CMD  = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_WR_DATA = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  beat;
    logic              owner_d;
    logic [ADDR_W-1:0] line_addr;
    logic [LINE_W-1:0] wline;
    logic [LINE_W-1:0] rbuf;
    logic [LINE_W-1:0] i_line;
    logic [LINE_W-1:0] d_line;
    logic [LINE_W-1:0] line_next;
    logic              d_req;
    logic              grant_d;
    logic              beat_hit;
    logic [ADDR_W-1:0] sel_addr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_d;
`endif

    always_comb begin
        d_req   = d_read | d_write;
        grant_d = d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // On contention, hand the port to whoever lost the previous grant.
        if (d_req && i_read) begin
            grant_d = ~last_d;
        end
`endif
        sel_addr = (grant_d ? d_addr : i_addr) & LINE_MASK;
    end

    assign beat_hit = bmem_rvalid && (bmem_raddr == line_addr);

    always_comb begin
        line_next = rbuf;
        line_next[beat*BEAT_W +: BEAT_W] = bmem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            beat      <= '0;
            owner_d   <= 1'b0;
            line_addr <= '0;
            wline     <= '0;
            rbuf      <= '0;
            i_line    <= '0;
            d_line    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (d_req || i_read) begin
                        owner_d   <= grant_d;
                        line_addr <= sel_addr;
                        wline     <= d_wdata;
                        beat      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_d    <= grant_d;
`endif
                        // A simultaneous read+write from dcache is treated as the write.
                        state     <= (grant_d && d_write) ? S_WR_DATA : S_RD_CMD;
                    end
                end
                S_RD_CMD: begin
                    if (bmem_ready) begin
                        state <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (beat_hit) begin
                        rbuf <= line_next;
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= S_RESP;
                            if (owner_d) begin
                                d_line <= line_next;
                            end else begin
                                i_line <= line_next;
                            end
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (bmem_ready) begin
                        if (beat == LAST_BEAT) begin
                            beat  <= '0;
                            state <= S_RESP;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bmem_addr  = line_addr;
    assign bmem_read  = (state == S_RD_CMD);
    assign bmem_write = (state == S_WR_DATA);
    assign bmem_wdata = (state == S_WR_DATA) ? wline[beat*BEAT_W +: BEAT_W] : '0;
    assign i_resp     = (state == S_RESP) && !owner_d;
    assign d_resp     = (state == S_RESP) && owner_d;
    assign i_rdata    = i_line;
    assign d_rdata    = d_line;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb/tb_mem_burst_arbiter.sv - directed self-checking bench for mem_burst_arbiter
module tb_mem_burst_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  i_addr;
    logic         i_read;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    always #5 clk = ~clk;

    mem_burst_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    localparam logic [255:0] L1 = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    localparam logic [255:0] L2 = 256'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7_C0C1C2C3C4C5C6C7_D0D1D2D3D4D5D6D7;
    localparam logic [255:0] L3 = 256'h0123456789ABCDEF_FEDCBA9876543210_1357913579135791_2468024680246802;
    localparam logic [255:0] L4 = 256'hCAFEF00D00000004_CAFEF00D00000003_CAFEF00D00000002_CAFEF00D00000001;
    localparam logic [255:0] W1 = 256'hDDDD000000000004_CCCC000000000003_BBBB000000000002_AAAA000000000001;
    localparam logic [255:0] W2 = 256'h5555555555555555_6666666666666666_7777777777777777_8888888888888888;

    int n_cmp = 0;
    int n_err = 0;

    int rd_cyc = 0;
    int wr_cyc = 0;
    int ipulse = 0;
    int dpulse = 0;
    int both_hi = 0;
    int wcnt = 0;
    logic [63:0] wbeat [0:15];

    always @(negedge clk) begin
        if (bmem_read) rd_cyc++;
        if (bmem_write) wr_cyc++;
        if (i_resp) ipulse++;
        if (d_resp) dpulse++;
        if (bmem_read && bmem_write) both_hi++;
        if (bmem_write && bmem_ready && wcnt < 16) begin
            wbeat[wcnt] = bmem_wdata;
            wcnt++;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller has raised the owner's request; grant happens on the next edge.
    task automatic read_txn(input bit dc, input logic [31:0] exp_addr, input logic [255:0] line,
                            input int bad_after, input string tag);
        int r0, ip0, dp0;
        r0 = rd_cyc; ip0 = ipulse; dp0 = dpulse;
        bmem_ready = 1'b1;
        tick();
        check({tag, "_cmd"}, bmem_read, 1);
        check({tag, "_addr"}, bmem_addr, exp_addr);
        tick();
        check({tag, "_rdcyc"}, rd_cyc - r0, 1);
        check({tag, "_cmd_off"}, bmem_read, 0);
        for (int b = 0; b < 4; b++) begin
            bmem_raddr  = exp_addr;
            bmem_rdata  = line[b*64 +: 64];
            bmem_rvalid = 1'b1;
            tick();
            if (b == bad_after) begin
                bmem_raddr = 32'h6000_1000;
                bmem_rdata = 64'hBADBADBADBADBAD0;
                tick();
                check({tag, "_noearly"}, {i_resp, d_resp}, 0);
            end
        end
        bmem_rvalid = 1'b0;
        check({tag, "_resp"}, {i_resp, d_resp}, dc ? 2'b01 : 2'b10);
        check({tag, "_line"}, dc ? d_rdata : i_rdata, line);
        if (dc) d_read = 1'b0; else i_read = 1'b0;
        tick();
        check({tag, "_resp_off"}, {i_resp, d_resp}, 0);
        check({tag, "_pulses"}, {ipulse - ip0, dpulse - dp0}, dc ? {32'd0, 32'd1} : {32'd1, 32'd0});
    endtask

    task automatic write_txn(input logic [31:0] exp_addr, input logic [255:0] line,
                             input logic [7:0] pat, input int n, input logic [255:0] exp_drd,
                             input string tag);
        int r0, w0, c0, dp0;
        r0 = rd_cyc; w0 = wcnt; c0 = wr_cyc; dp0 = dpulse;
        tick();
        check({tag, "_addr"}, bmem_addr, exp_addr);
        for (int i = 0; i < n; i++) begin
            bmem_ready = pat[i];
            check({tag, "_wr_hi"}, {bmem_write, bmem_read}, 2'b10);
            tick();
        end
        check({tag, "_resp"}, {i_resp, d_resp}, 2'b01);
        check({tag, "_wr_off"}, bmem_write, 0);
        d_write = 1'b0;
        d_read = 1'b0;
        bmem_ready = 1'b1;
        tick();
        check({tag, "_beats"}, wcnt - w0, 4);
        for (int k = 0; k < 4; k++) begin
            check({tag, "_wbeat"}, wbeat[w0 + k], line[k*64 +: 64]);
        end
        check({tag, "_wrcyc"}, wr_cyc - c0, n);
        check({tag, "_no_read"}, rd_cyc - r0, 0);
        check({tag, "_dpulse"}, dpulse - dp0, 1);
        check({tag, "_drdata"}, d_rdata, exp_drd);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_irdata"}, i_rdata, 0);
        check({tag, "_drdata"}, d_rdata, 0);
        check({tag, "_ctl"}, {bmem_read, bmem_write, i_resp, d_resp}, 0);
        check({tag, "_baddr"}, bmem_addr, 0);
        check({tag, "_bwdata"}, bmem_wdata, 0);
    endtask

    initial begin
        int ip0;
        bit first_d;
        rst_n = 1'b0;
        i_addr = '0; i_read = 1'b0;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        tick();
        tick();
        check_all_zero("rst");
        rst_n = 1'b1;
        tick();
        check_all_zero("post_rst");

        // Lone icache read
        i_addr = 32'h6000_0044;
        i_read = 1'b1;
        read_txn(1'b0, 32'h6000_0040, L1, -1, "t1");
        check("t1_drdata", d_rdata, 0);

        // dcache writeback with back-pressure
        d_addr = 32'h6000_0100;
        d_wdata = W1;
        d_write = 1'b1;
        write_txn(32'h6000_0100, W1, 8'b0010_1101, 6, 256'd0, "t2");
        check("t2_irdata_held", i_rdata, L1);

        // Contention right after a dcache grant, plus a mismatched beat
`ifdef MEM_ARB_ROUND_ROBIN_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        i_addr = 32'h6000_0208; d_addr = 32'h6000_031C;
        i_read = 1'b1; d_read = 1'b1;
        if (first_d) begin
            read_txn(1'b1, 32'h6000_0300, L3, 1, "t3_first_d");
            read_txn(1'b0, 32'h6000_0200, L2, -1, "t3_then_i");
        end else begin
            read_txn(1'b0, 32'h6000_0200, L2, 1, "t3_first_i");
            read_txn(1'b1, 32'h6000_0300, L3, -1, "t3_then_d");
        end
        check("t3_irdata", i_rdata, L2);
        check("t3_drdata", d_rdata, L3);

        // Reset in the middle of a read burst
        i_addr = 32'h6000_0400;
        i_read = 1'b1;
        bmem_ready = 1'b1;
        tick();
        tick();
        for (int b = 0; b < 2; b++) begin
            bmem_raddr = 32'h6000_0400;
            bmem_rdata = 64'hDEAD_0000_0000_0000 | 64'(b);
            bmem_rvalid = 1'b1;
            tick();
        end
        ip0 = ipulse;
        rst_n = 1'b0;
        i_read = 1'b0;
        #1;
        check_all_zero("t4_inrst");
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        bmem_rvalid = 1'b0;
        check("t4_idle_beats", {i_resp, d_resp, bmem_read}, 0);
        check("t4_no_pulse", ipulse - ip0, 0);
        check("t4_irdata_clr", i_rdata, 0);
        i_read = 1'b1;
        read_txn(1'b0, 32'h6000_0400, L4, -1, "t4");

        // Read and write together from dcache: the write wins
        d_addr = 32'h6000_0500;
        d_wdata = W2;
        d_read = 1'b1;
        d_write = 1'b1;
        write_txn(32'h6000_0500, W2, 8'b0000_1111, 4, 256'd0, "t5");

        check("never_rd_and_wr", both_hi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
